// File: rtl/alu_console_p_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_console_p_if
// Brief    : Operator bus of the ALU console: data/step/chain entry towards
//            the core, display/phase/busy back towards the display driver.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_console_p_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] data;
   logic             step;
   logic             chain;
   logic [WIDTH-1:0] display;
   logic [2:0]       phase;
   logic             busy;

   // Operator side: switches/button drive, display side observes.
   modport master (
      output data, step, chain,
      input  display, phase, busy
   );

   // Console core side.
   modport slave (
      input  data, step, chain,
      output display, phase, busy
   );
endinterface
`default_nettype wire

// File: rtl/alu_console_p.sv
`default_nettype none
// ============================================================================
// Module   : alu_console_p
// Brief    : Step-driven ALU console. Operands and opcode are entered one at
//            a time, single-cycle ops and an iterative shift-add multiply are
//            executed, then the display pages between result and flags.
//            Chain mode reuses the last result as operand A.
// Revision : 1.0 - initial release
// ============================================================================
module alu_console_p #(
   parameter int WIDTH = 16,
   parameter int OPW   = 4,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  wire logic      clk,
   input  wire logic      rst,
   alu_console_p_if.slave bus
);

   // ------------------------------------------------------------------------
   // State and opcode encodings
   // ------------------------------------------------------------------------
   localparam logic [2:0] S_LOAD_A   = 3'd0;
   localparam logic [2:0] S_LOAD_B   = 3'd1;
   localparam logic [2:0] S_LOAD_OP  = 3'd2;
   localparam logic [2:0] S_EXEC     = 3'd3;
   localparam logic [2:0] S_SHOW_RES = 3'd4;
   localparam logic [2:0] S_SHOW_FLG = 3'd5;

   localparam logic [OPW-1:0] OP_ADD = OPW'(0);
   localparam logic [OPW-1:0] OP_SUB = OPW'(1);
   localparam logic [OPW-1:0] OP_AND = OPW'(2);
   localparam logic [OPW-1:0] OP_OR  = OPW'(3);
   localparam logic [OPW-1:0] OP_XOR = OPW'(4);
   localparam logic [OPW-1:0] OP_NOT = OPW'(5);
   localparam logic [OPW-1:0] OP_SLL = OPW'(6);
   localparam logic [OPW-1:0] OP_SRL = OPW'(7);
   localparam logic [OPW-1:0] OP_SRA = OPW'(8);
   localparam logic [OPW-1:0] OP_ROL = OPW'(9);
   localparam logic [OPW-1:0] OP_MUL = OPW'(10);

   localparam int MSB = WIDTH - 1;

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   logic                 step_q;
   logic [2:0]           state_q, state_d;
   logic [WIDTH-1:0]     a_q, b_q;
   logic [OPW-1:0]       op_q;
   logic [WIDTH-1:0]     result_q;
   logic [4:0]           flags_q;
   logic [WIDTH-1:0]     display_q, display_d;
   logic                 busy_d;

   logic [2*WIDTH-1:0]   mul_acc_q;
   logic [2*WIDTH-1:0]   mul_mcand_q;
   logic [WIDTH-1:0]     mul_mplier_q;
   logic [SHW-1:0]       mul_cnt_q;

   // ------------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------------
   logic                 w_stp;
   logic [SHW-1:0]       w_amt;
   logic [WIDTH:0]       w_add;
   logic [WIDTH-1:0]     w_sub;
   logic [WIDTH:0]       w_sll;      // bit WIDTH is the last bit shifted out
   logic [WIDTH:0]       w_srl;      // bit 0 is the last bit shifted out
   logic [WIDTH:0]       w_sra;
   logic [2*WIDTH-1:0]   w_rol2;     // upper half is the rotated operand
   logic [2*WIDTH-1:0]   w_mul_acc_nxt;
   logic                 w_mul_last;
   logic                 w_exec_done;
   logic [WIDTH-1:0]     w_res;
   logic                 w_c, w_v, w_err;
   logic [4:0]           w_flags;

   assign w_stp = bus.step & ~step_q;
   assign w_amt = b_q[SHW-1:0];

   // Shifting a one-bit-extended operand keeps the shifted-out bit in the
   // extension, so amount 0 naturally yields C = 0.
   assign w_add  = {1'b0, a_q} + {1'b0, b_q};
   assign w_sub  = a_q - b_q;
   assign w_sll  = {1'b0, a_q} << w_amt;
   assign w_srl  = {a_q, 1'b0} >> w_amt;
   assign w_sra  = $unsigned($signed({a_q, 1'b0}) >>> w_amt);
   assign w_rol2 = {a_q, a_q} << w_amt;

   // One shift-add step: the accumulator absorbs the current partial product.
   assign w_mul_acc_nxt = mul_acc_q + (mul_mplier_q[0] ? mul_mcand_q : '0);
   assign w_mul_last    = (mul_cnt_q == SHW'(WIDTH - 1));

   // Single-cycle ops finish on the first EXEC clock, MUL on its last step.
   assign w_exec_done = (state_q == S_EXEC) && ((op_q != OP_MUL) || w_mul_last);

   // ALU: result plus carry/overflow/error for the current opcode.
   always_comb begin
      w_res = '0;
      w_c   = 1'b0;
      w_v   = 1'b0;
      w_err = 1'b0;
      case (op_q)
         OP_ADD: begin
            w_res = w_add[WIDTH-1:0];
            w_c   = w_add[WIDTH];
            w_v   = (a_q[MSB] == b_q[MSB]) && (w_add[MSB] != a_q[MSB]);
         end
         OP_SUB: begin
            w_res = w_sub;
            w_c   = (a_q < b_q);
            w_v   = (a_q[MSB] != b_q[MSB]) && (w_sub[MSB] != a_q[MSB]);
         end
         OP_AND: w_res = a_q & b_q;
         OP_OR:  w_res = a_q | b_q;
         OP_XOR: w_res = a_q ^ b_q;
         OP_NOT: w_res = ~a_q;
         OP_SLL: begin
            w_res = w_sll[WIDTH-1:0];
            w_c   = w_sll[WIDTH];
         end
         OP_SRL: begin
            w_res = w_srl[WIDTH:1];
            w_c   = w_srl[0];
         end
         OP_SRA: begin
            w_res = w_sra[WIDTH:1];
            w_c   = w_sra[0];
         end
         OP_ROL: w_res = w_rol2[2*WIDTH-1:WIDTH];
         OP_MUL: begin
            w_res = w_mul_acc_nxt[WIDTH-1:0];
            w_c   = |w_mul_acc_nxt[2*WIDTH-1:WIDTH];
         end
         default: w_err = 1'b1;
      endcase
   end

   assign w_flags = {w_err, w_v, w_c, w_res[MSB], (w_res == '0)};

   // ------------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------------
   // State register; also tracks the button level for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_LOAD_A;
         step_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= bus.step;
      end
   end

   // Next-state logic; button events during EXEC are dropped, not queued.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_LOAD_A:   if (w_stp) state_d = S_LOAD_B;
         S_LOAD_B:   if (w_stp) state_d = S_LOAD_OP;
         S_LOAD_OP:  if (w_stp) state_d = S_EXEC;
         S_EXEC:     if (w_exec_done) state_d = S_SHOW_RES;
         S_SHOW_RES: if (w_stp) state_d = S_SHOW_FLG;
         S_SHOW_FLG: if (w_stp) state_d = bus.chain ? S_LOAD_B : S_LOAD_A;
         default:    state_d = S_LOAD_A;
      endcase
   end

   // Output decode: busy flag and the word to be registered onto the display.
   always_comb begin
      busy_d    = (state_q == S_EXEC);
      display_d = '0;
      case (state_q)
         S_LOAD_A, S_LOAD_B, S_LOAD_OP: display_d = bus.data;
         S_SHOW_RES:                    display_d = result_q;
         S_SHOW_FLG:                    display_d = {{(WIDTH-5){1'b0}}, flags_q};
         default:                       display_d = '0;
      endcase
   end

   // Display register: one clock behind the state/data it reflects.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) display_q <= '0;
      else     display_q <= display_d;
   end

   // ------------------------------------------------------------------------
   // Datapath
   // ------------------------------------------------------------------------
   // Operand/opcode capture, chain reload of A, and result/flags write-back.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         if (state_q == S_LOAD_A && w_stp)  a_q  <= bus.data;
         if (state_q == S_LOAD_B && w_stp)  b_q  <= bus.data;
         if (state_q == S_LOAD_OP && w_stp) op_q <= bus.data[OPW-1:0];
         if (state_q == S_SHOW_FLG && w_stp && bus.chain) a_q <= result_q;
         if (w_exec_done) begin
            result_q <= w_res;
            flags_q  <= w_flags;
         end
      end
   end

   // Multiplier: primed when the opcode is committed, then one shift-add per
   // EXEC clock for exactly WIDTH clocks.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mul_acc_q    <= '0;
         mul_mcand_q  <= '0;
         mul_mplier_q <= '0;
         mul_cnt_q    <= '0;
      end else if (state_q == S_LOAD_OP && w_stp) begin
         mul_acc_q    <= '0;
         mul_mcand_q  <= {{WIDTH{1'b0}}, a_q};
         mul_mplier_q <= b_q;
         mul_cnt_q    <= '0;
      end else if (state_q == S_EXEC && op_q == OP_MUL) begin
         mul_acc_q    <= w_mul_acc_nxt;
         mul_mcand_q  <= {mul_mcand_q[2*WIDTH-2:0], 1'b0};
         mul_mplier_q <= {1'b0, mul_mplier_q[WIDTH-1:1]};
         mul_cnt_q    <= mul_cnt_q + SHW'(1);
      end
   end

   assign bus.display = display_q;
   assign bus.phase   = state_q;
   assign bus.busy    = busy_d;

endmodule
`default_nettype wire

// File: tb/tb_alu_console_p.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_console_p
// Brief    : Directed self-checking bench for alu_console_p. A transaction
//            level ALU model supplies expected result/flags; a per-cycle
//            monitor checks phase and busy against the expected sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_console_p;
   localparam int W = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alu_console_p_if #(.WIDTH(W)) bus ();

   alu_console_p #(.WIDTH(W), .OPW(4), .SHW(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int         vectors     = 0;
   int         miscompares = 0;
   logic [2:0] exp_phase;
   logic       exp_busy;
   bit         mon_en      = 1'b0;
   logic [W-1:0] last_res  = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference ALU from the opcode table: returns {ERR,V,C,N,Z,result}.
   function automatic logic [W+4:0] model(input logic [3:0] op,
                                          input logic [W-1:0] a,
                                          input logic [W-1:0] b);
      longint ua, ub, sa, sb, r, sr;
      int     amt;
      logic   c, v, e;
      logic [W-1:0] res;
      ua = longint'(a);
      ub = longint'(b);
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      amt = int'(b[3:0]);
      c = 1'b0; v = 1'b0; e = 1'b0; r = 0;
      case (op)
         4'd0: begin r = ua + ub; c = (r >= (64'sd1 << W)); sr = sa + sb;
                     v = (sr > 32767) || (sr < -32768); end
         4'd1: begin r = ua - ub; c = (ua < ub); sr = sa - sb;
                     v = (sr > 32767) || (sr < -32768); end
         4'd2: r = ua & ub;
         4'd3: r = ua | ub;
         4'd4: r = ua ^ ub;
         4'd5: r = ~ua;
         4'd6: begin r = ua << amt; c = (amt != 0) && (((ua >> (W - amt)) & 1) != 0); end
         4'd7: begin r = ua >> amt; c = (amt != 0) && (((ua >> (amt - 1)) & 1) != 0); end
         4'd8: begin r = sa >>> amt; c = (amt != 0) && (((ua >> (amt - 1)) & 1) != 0); end
         4'd9: r = (ua << amt) | (ua >> (W - amt));
         4'd10: begin r = ua * ub; c = ((r >> W) != 0); end
         default: begin r = 0; e = 1'b1; end
      endcase
      res = r[W-1:0];
      return {e, v, c, res[W-1], (res == '0), res};
   endfunction

   // Per-cycle monitor of the control outputs.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("phase", {29'd0, bus.phase}, {29'd0, exp_phase});
         chk("busy",  {31'd0, bus.busy},  {31'd0, exp_busy});
      end
   end

   task automatic press(input logic [2:0] nxt);
      bus.step = 1'b1;
      @(posedge clk); #1;
      bus.step  = 1'b0;
      exp_phase = nxt;
      @(posedge clk); #1;
   endtask

   task automatic enter(input logic [W-1:0] val, input logic [2:0] nxt);
      bus.data = val;
      @(posedge clk); #1;
      chk("echo", {16'd0, bus.display}, {16'd0, val});
      press(nxt);
   endtask

   task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op,
                      input bit chain_a, input bit chain_nxt,
                      input bit lit, input logic [W-1:0] lit_res, input logic [4:0] lit_flg);
      logic [W+4:0] m;
      logic [W-1:0] aa;
      int n;
      aa = chain_a ? last_res : a;
      m  = model(op, aa, b);
      if (!chain_a) enter(a, 3'd1);
      enter(b, 3'd2);
      bus.data = {12'd0, op};
      @(posedge clk); #1;
      chk("echo_op", {16'd0, bus.display}, {28'd0, op});
      bus.step = 1'b1;
      @(posedge clk); #1;
      bus.step  = 1'b0;
      exp_phase = 3'd3;
      exp_busy  = 1'b1;
      n = (op == 4'd10) ? W : 1;
      for (int i = 1; i <= n; i++) begin
         if (op == 4'd10) begin
            if (i == 3 || i == 8) bus.step = 1'b1;
            if (i == 5 || i == 9) bus.step = 1'b0;
         end
         @(posedge clk); #1;
         if (op == 4'd10 && i == 4) chk("exec_display", {16'd0, bus.display}, 32'd0);
      end
      exp_phase = 3'd4;
      exp_busy  = 1'b0;
      @(posedge clk); #1;
      chk("result", {16'd0, bus.display}, {16'd0, m[W-1:0]});
      if (lit) chk("result_lit", {16'd0, bus.display}, {16'd0, lit_res});
      press(3'd5);
      chk("flags", {16'd0, bus.display}, {27'd0, m[W+4:W]});
      if (lit) chk("flags_lit", {16'd0, bus.display}, {27'd0, lit_flg});
      bus.chain = chain_nxt;
      press(chain_nxt ? 3'd1 : 3'd0);
      bus.chain = 1'b0;
      last_res  = m[W-1:0];
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst       = 1'b1;
      bus.data  = '0;
      bus.step  = 1'b0;
      bus.chain = 1'b0;
      exp_phase = 3'd0;
      exp_busy  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      mon_en = 1'b1;
      chk("reset_display", {16'd0, bus.display}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      run(16'h7FFF, 16'h0001, 4'd0,  0, 0, 1, 16'h8000, 5'h0A);
      run(16'h0003, 16'h0005, 4'd1,  0, 0, 1, 16'hFFFE, 5'h06);
      run(16'h0100, 16'h0100, 4'd10, 0, 0, 1, 16'h0000, 5'h05);
      run(16'h8001, 16'h0001, 4'd8,  0, 0, 1, 16'hC000, 5'h06);
      run(16'h1234, 16'h0010, 4'd6,  0, 0, 1, 16'h1234, 5'h00);
      run(16'h0002, 16'h0003, 4'd0,  0, 1, 1, 16'h0005, 5'h00);
      run(16'h0000, 16'h0004, 4'd0,  1, 0, 1, 16'h0009, 5'h00);
      run(16'h1234, 16'h5678, 4'd15, 0, 0, 1, 16'h0000, 5'h11);
      run(16'h8001, 16'h0004, 4'd9,  0, 0, 1, 16'h0018, 5'h00);
      run(16'h8003, 16'h0001, 4'd7,  0, 0, 1, 16'h4001, 5'h04);
      run(16'h8000, 16'h0001, 4'd1,  0, 0, 1, 16'h7FFF, 5'h08);
      run(16'h8001, 16'h0001, 4'd6,  0, 0, 1, 16'h0002, 5'h04);
      run(16'hFFFF, 16'h0000, 4'd5,  0, 0, 1, 16'h0000, 5'h01);
      run(16'h1234, 16'h0056, 4'd10, 0, 0, 0, 16'h0000, 5'h00);
      run(16'hF0F0, 16'h3C3C, 4'd2,  0, 0, 0, 16'h0000, 5'h00);
      run(16'hF0F0, 16'h3C3C, 4'd3,  0, 0, 0, 16'h0000, 5'h00);
      run(16'hF0F0, 16'h3C3C, 4'd4,  0, 0, 0, 16'h0000, 5'h00);

      // Reset in the middle of a multiply.
      enter(16'h00FF, 3'd1);
      enter(16'h0101, 3'd2);
      bus.data = 16'h000A;
      @(posedge clk); #1;
      bus.step = 1'b1;
      @(posedge clk); #1;
      bus.step  = 1'b0;
      exp_phase = 3'd3;
      exp_busy  = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         @(posedge clk); #1;
      end
      rst       = 1'b1;
      exp_phase = 3'd0;
      exp_busy  = 1'b0;
      #1;
      chk("rst_phase",   {29'd0, bus.phase},   32'd0);
      chk("rst_busy",    {31'd0, bus.busy},    32'd0);
      chk("rst_display", {16'd0, bus.display}, 32'd0);
      bus.data = 16'h5A5A;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_echo", {16'd0, bus.display}, 32'h0000_5A5A);

      run(16'hFFFF, 16'h0001, 4'd0,  0, 0, 1, 16'h0000, 5'h05);

      mon_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/alu_console_p.md
Name: alu_console_p

Overview:
Parametrised successor to the switch-driven ALU console. The operator enters operand A, operand B and an opcode one at a time on a shared data bus, each committed by a step button. The block executes single-cycle ops and an iterative multi-cycle multiply, then pages the display between result and flags. It adds an accumulate/chain mode, in which the previous result becomes the next operand A without re-entry. It sits between the board switches/button and the display driver.

Parameters:
WIDTH, 16, operand/result/display width in bits (minimum 8).
OPW, 4, opcode width; opcode taken from data[OPW-1:0].
SHW, $clog2(WIDTH), shift-amount width; shift amount is B[SHW-1:0].

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  asynchronous, active-high reset.
data  input  WIDTH  operand/opcode entry bus, synchronous to clk.
step  input  1  commit button, synchronous level; the block acts on its rising edge.
chain  input  1  sampled when leaving SHOW_FLG; 1 means reuse result as A.
display  output  WIDTH  registered display word.
phase  output  3  current state encoding.
busy  output  1  1 while in EXEC.

Behaviour:
- Reset is asynchronous and active-high. On reset: state=LOAD_A (phase=0); A, B, op, result, flags, display, busy and step_q all 0. Reset mid-EXEC abandons the multiply, with no residual state.
- Edge detect: one register step_q; stp = step & ~step_q. A held step yields exactly one event.
- States and encodings: LOAD_A=0, LOAD_B=1, LOAD_OP=2, EXEC=3, SHOW_RES=4, SHOW_FLG=5. Encodings 6 and 7 are illegal and recover to LOAD_A on the next clock.
- LOAD_A: on stp, A<=data, go to LOAD_B.
- LOAD_B: on stp, B<=data, go to LOAD_OP.
- LOAD_OP: on stp, op<=data[OPW-1:0], go to EXEC.
- EXEC: busy=1; stp is ignored and not queued.
  - Single-cycle ops: result and flags are written on the first EXEC clock; next state is SHOW_RES.
  - MUL: exactly WIDTH EXEC cycles of shift-add; then SHOW_RES.
- SHOW_RES: on stp, go to SHOW_FLG.
- SHOW_FLG: on stp, if chain=1 then A<=result and go to LOAD_B; otherwise go to LOAD_A.
- display is registered, 1-cycle latency from the state/data change:
  - LOAD_* states: display = data (echo).
  - EXEC: display = 0.
  - SHOW_RES: display = result.
  - SHOW_FLG: display = flags zero-extended to WIDTH.
- Opcodes (all arithmetic modulo 2^WIDTH):
  - 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 NOT A.
  - 6 SLL, 7 SRL, 8 SRA, 9 ROL; shift amount is B[SHW-1:0].
  - 10 MUL: low WIDTH bits of the unsigned product.
  - Any other opcode: result=0, ERR=1.
- Flags: bit0 Z (result==0), bit1 N (result MSB), bit2 C, bit3 V, bit4 ERR; upper bits 0.
- C by op:
  - ADD: carry out.
  - SUB: borrow, i.e. A<B unsigned.
  - SLL/SRL/SRA: last bit shifted out; 0 when amount=0.
  - ROL: 0.
  - MUL: 1 if any bit of the high product half is nonzero.
  - Logic ops: 0.
- V: signed overflow for ADD/SUB; 0 for all other ops.
- Z and N are valid for every op, including the illegal-opcode case.
- Flags and result hold until the next EXEC completes.

Test Plan:
- Reset, then ADD 0x7FFF + 0x0001 (three step pulses, one per entry) -> SHOW_RES display 0x8000; after next step, display 0x000A (N,V).
- SUB 0x0003 - 0x0005 -> result 0xFFFE; flags 0x0006 (N,C).
- MUL 0x0100 * 0x0100 -> busy high for exactly 16 cycles, step pulses during EXEC have no effect; result 0x0000; flags 0x0005 (Z,C).
- SRA 0x8001 by B=0x0001 -> 0xC000, flags 0x0006. SLL by B=0x0010 (amount field = 0) -> result = A, C=0.
- Chain: ADD 2+3 -> 5; at SHOW_FLG step with chain=1 -> phase=1; enter B=4, op=0 -> result 0x0009. Repeat with chain=0 -> phase=0.
- Opcode 0xF -> result 0, flags 0x0011 (ERR,Z). Assert rst mid-MUL at cycle 7 -> phase=0, busy=0 and display=0 immediately; one cycle after release, display echoes data.
